// File: rtl/mc_sample_fifo_pkg.sv
// Shared constants and width helpers for the multi-channel sample path.
// The sample front-end blocks reuse these as well.
package mc_sample_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 9;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_AFULL_LEVEL = 12;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width; a single channel still gets a 1-bit tag.
  function automatic int unsigned ch_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int unsigned DEF_AW = clog2(DEF_DEPTH);
  localparam int unsigned DEF_CW = ch_width(DEF_NUM_CH);

endpackage

// File: rtl/mc_sample_fifo_fifo_core.sv
// Single-channel circular buffer: storage, pointers, level, flags and
// the sticky overflow bit for one microphone channel.
module fifo_core
  import mc_sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned AFULL_LEVEL = DEF_AFULL_LEVEL,
  localparam int unsigned AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [AW:0]           level,
  output logic                  ready,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  accept;
  logic                  take;
  logic                  drop;

  assign ready       = (level != (AW+1)'(DEPTH));
  assign empty       = (level == '0);
  assign almost_full = (level >= (AW+1)'(AFULL_LEVEL));
  assign accept      = push && ready;
  assign drop        = push && !ready;
  assign take        = pop && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (take)   rd_ptr <= rd_ptr + 1'b1;
      case ({accept, take})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_sample_fifo.sv
// NUM_CH per-channel sample FIFOs merged into one tagged stream through a
// round-robin arbiter and a registered valid/ready output stage.
module mc_sample_fifo
  import mc_sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned AFULL_LEVEL = DEF_AFULL_LEVEL,
  localparam int unsigned AW         = clog2(DEPTH),
  localparam int unsigned CW         = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CW-1:0]                out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*(AW+1)-1:0]     level,
  output logic [NUM_CH-1:0]            almost_full,
  output logic [NUM_CH-1:0]            overflow,
  input  logic [NUM_CH-1:0]            clr_overflow
);

  logic [DATA_WIDTH-1:0] dout [NUM_CH];
  logic [NUM_CH-1:0]     nonempty;
  logic [NUM_CH-1:0]     pop;
  logic [CW-1:0]         rr_ptr;
  logic [CW-1:0]         grant;
  logic [CW-1:0]         rr_next;
  logic                  found;
  logic                  load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic empty;

    fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AFULL_LEVEL(AFULL_LEVEL)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (in_valid[c]),
      .din         (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .pop         (pop[c]),
      .clr_overflow(clr_overflow[c]),
      .dout        (dout[c]),
      .level       (level[c*(AW+1) +: (AW+1)]),
      .ready       (in_ready[c]),
      .empty       (empty),
      .almost_full (almost_full[c]),
      .overflow    (overflow[c])
    );

    assign nonempty[c] = !empty;
  end

  assign load = !out_valid || out_ready;

  // Search starts at rr_ptr, which already holds (last grant + 1) mod NUM_CH.
  always_comb begin
    logic [CW:0] idx;
    idx   = '0;
    found = 1'b0;
    grant = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr} + (CW+1)'(i);
      if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
      if (!found && nonempty[idx[CW-1:0]]) begin
        found = 1'b1;
        grant = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && found) pop[grant] = 1'b1;
    rr_next = (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (found) begin
        out_data  <= dout[grant];
        out_ch    <= grant;
        out_valid <= 1'b1;
        rr_ptr    <= rr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_sample_fifo.sv
// Randomised and directed bench for mc_sample_fifo against a queue-based
// reference model of the per-channel buffers and round-robin merge.
module tb_mc_sample_fifo;

  localparam int unsigned DW    = 9;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NCH   = 4;
  localparam int unsigned AFL   = 12;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH*DW-1:0]     in_data = '0;
  logic [NCH-1:0]        in_valid = '0;
  logic [NCH-1:0]        in_ready;
  logic [DW-1:0]         out_data;
  logic [CW-1:0]         out_ch;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [NCH*(AW+1)-1:0] level;
  logic [NCH-1:0]        almost_full;
  logic [NCH-1:0]        overflow;
  logic [NCH-1:0]        clr_overflow = '0;

  mc_sample_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_CH     (NCH),
    .AFULL_LEVEL(AFL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: one queue per channel plus the output register.
  logic [DW-1:0] mq [NCH][$];
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  int unsigned   m_ch = 0;
  int unsigned   m_rr = 0;
  bit            m_ovf [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int unsigned sz [NCH];
    int unsigned c;
    bit found;
    if (rst) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        mq[k].delete();
        m_ovf[k] = 1'b0;
      end
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = 0;
      return;
    end
    for (int unsigned k = 0; k < NCH; k++) sz[k] = mq[k].size();
    if (!m_valid || out_ready) begin
      found = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        c = (m_rr + i) % NCH;
        if (!found && mq[c].size() != 0) begin
          found  = 1'b1;
          m_data = mq[c].pop_front();
          m_ch   = c;
        end
      end
      if (found) m_rr = (m_ch + 1) % NCH;
      m_valid = found;
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (in_valid[k] && sz[k] == DEPTH) m_ovf[k] = 1'b1;
      else begin
        if (in_valid[k]) mq[k].push_back(in_data[k*DW +: DW]);
        if (clr_overflow[k]) m_ovf[k] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int unsigned k = 0; k < NCH; k++) begin
      check($sformatf("level%0d", k), 64'(level[k*(AW+1) +: (AW+1)]), 64'(mq[k].size()));
      check($sformatf("in_ready%0d", k), 64'(in_ready[k]), 64'(mq[k].size() != DEPTH));
      check($sformatf("almost_full%0d", k), 64'(almost_full[k]), 64'(mq[k].size() >= AFL));
      check($sformatf("overflow%0d", k), 64'(overflow[k]), 64'(m_ovf[k]));
    end
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_data", 64'(out_data), 64'(m_data));
      check("out_ch", 64'(out_ch), 64'(m_ch));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    in_valid = '0; clr_overflow = '0; in_data = '0;
  endtask

  task automatic put(input int unsigned ch, input logic [DW-1:0] d);
    in_valid = '0;
    in_valid[ch] = 1'b1;
    in_data = '0;
    in_data[ch*DW +: DW] = d;
  endtask

  logic [DW-1:0] hold_d;
  logic [CW-1:0] hold_ch;
  int unsigned   prev_ch;

  initial begin
    // Reset then idle
    rst = 1'b1; cycle(); cycle();
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'hF);
    rst = 1'b0;
    cycle(); cycle();

    // Single word on ch2, visible one cycle after acceptance
    out_ready = 1'b1;
    put(2, 9'h1A5); cycle();
    idle_inputs(); cycle();
    check("first_word_data", 64'(out_data), 64'h1A5);
    check("first_word_ch", 64'(out_ch), 64'd2);
    check("first_word_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;

    // Fill ch0 to full behind a held output word, then overflow it
    for (int unsigned i = 1; i <= 17; i++) begin
      put(0, DW'(i)); cycle();
      if (i == 11) check("afull_11", 64'(almost_full[0]), 64'd0);
      if (i == 12) check("afull_12", 64'(almost_full[0]), 64'd1);
      if (i == 15) check("ready_15", 64'(in_ready[0]), 64'd1);
      if (i == 16) check("ready_16", 64'(in_ready[0]), 64'd0);
    end
    check("ovf_after_17", 64'(overflow[0]), 64'd1);
    idle_inputs(); out_ready = 1'b1;
    cycle();
    for (int unsigned i = 1; i <= 16; i++) begin
      check("drain_order", 64'(out_data), 64'(i));
      cycle();
    end
    clr_overflow[0] = 1'b1; cycle();
    clr_overflow = '0; cycle();
    check("ovf_cleared", 64'(overflow[0]), 64'd0);

    // Wrap-around: 40 words through ch1 with random backpressure
    for (int unsigned i = 0; i < 40; ) begin
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready[1]) begin
        put(1, DW'($urandom_range(0, 511)));
        i++;
      end else idle_inputs();
      cycle();
    end
    idle_inputs(); out_ready = 1'b1;
    repeat (20) cycle();

    // Fairness with every channel kept non-empty
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      in_valid = '1;
      in_data = NCH*DW'({$urandom(), $urandom()});
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    prev_ch = out_ch;
    for (int unsigned i = 0; i < 16; i++) begin
      in_valid = '1;
      in_data = NCH*DW'({$urandom(), $urandom()});
      cycle();
      check("rr_sequence", 64'(out_ch), 64'((prev_ch + 1) % NCH));
      prev_ch = out_ch;
    end

    // Backpressure: held output stays stable while writes continue
    out_ready = 1'b0; idle_inputs(); cycle();
    hold_d = out_data; hold_ch = out_ch;
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 4'b0101;
      in_data = NCH*DW'({$urandom(), $urandom()});
      cycle();
      check("hold_data", 64'(out_data), 64'(hold_d));
      check("hold_ch", 64'(out_ch), 64'(hold_ch));
      check("hold_valid", 64'(out_valid), 64'd1);
    end

    // Reset mid-stream with data in all channels
    idle_inputs(); out_ready = 1'b1;
    rst = 1'b1; cycle();
    rst = 1'b0;
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      cycle();
      check("no_stale", 64'(out_valid), 64'd0);
    end

    // Random soak
    for (int unsigned i = 0; i < 400; i++) begin
      in_valid = NCH'($urandom());
      in_data = NCH*DW'({$urandom(), $urandom()});
      out_ready = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 7) == 0) ? NCH'($urandom()) : '0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
